// File: rtl/hcms_pkg.sv
// Shared types and constants for the HCMS-29xx display transmitter.
package hcms_pkg;

   typedef enum logic [2:0] {
      RST_HOLD,
      IDLE,
      SETUP,
      SHIFT,
      NEXT,
      LATCH
   } state_t;

   // Register select values driven on RS for a frame
   localparam logic REG_DOT  = 1'b0;
   localparam logic REG_CTRL = 1'b1;

   // Control-word layout: bit 7 selects CW0 (0) or CW1 (1)
   localparam int CW_SEL_BIT      = 7;
   localparam int CW0_SLEEP_N_BIT = 6;  // 1 = normal operation
   localparam int CW0_PEAK_LSB    = 4;  // bits 5:4 peak current
   localparam int CW0_PWM_LSB     = 0;  // bits 3:0 PWM brightness
   localparam int CW1_SIMUL_BIT   = 0;  // 1 = simultaneous data out, 0 = serial

   function automatic logic [7:0] cw0(input logic [1:0] peak, input logic [3:0] pwm);
      return {1'b0, 1'b1, peak, pwm};
   endfunction

   function automatic logic [7:0] cw1(input logic simul);
      return {1'b1, 6'b0, simul};
   endfunction

endpackage

// File: rtl/hcms_stream_tx_if.sv
// Ready/valid byte stream with frame-last and register-select qualifiers.
interface hcms_stream_tx_if #(
   parameter int DATA_W = 8
) ();
   logic [DATA_W-1:0] s_data;
   logic              s_valid;
   logic              s_last;
   logic              s_cmd;
   logic              s_ready;

   modport master (output s_data, s_valid, s_last, s_cmd, input s_ready);
   modport slave  (input s_data, s_valid, s_last, s_cmd, output s_ready);
endinterface

// File: rtl/hcms_tick_div.sv
// Half-period counter: tick on the last of every DIV cycles, restartable.
module hcms_tick_div #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic tick
);
   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt;

   assign tick = (cnt == CW'(DIV - 1));

   // count 0..DIV-1, wrapping on tick; restart realigns to a fresh period
   always_ff @(posedge clk) begin
      if (rst || restart || tick) cnt <= '0;
      else                        cnt <= cnt + CW'(1);
   end
endmodule

// File: rtl/hcms_stream_tx.sv
// Serial transmitter for chained HCMS-29xx displays: frames a byte stream
// under CE, shifts MSB first on a divided clock and sequences display reset.
module hcms_stream_tx
   import hcms_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int CLK_DIV      = 4,
   parameter int MAX_FRAME    = 160,
   parameter int RESET_CYCLES = 32
) (
   input  logic              clk,
   input  logic              rst,
   hcms_stream_tx_if.slave   s,
   input  logic              disp_rst,
   output logic              busy,
   output logic              done,
   output logic              err_len,
   output logic              ser_data,
   output logic              ser_clk,
   output logic              reg_sel,
   output logic              ce_n,
   output logic              reset_n
);
   localparam int BW  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int WCW = $clog2(MAX_FRAME + 1);
   localparam int RCW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

   state_t            state_q, state_d;
   logic              tick, restart, accept, ready_w, last_bit;
   logic              half_q, ser_q, rs_q, last_q, trunc_q, pend_q, err_q;
   logic [DATA_W-1:0] sh_q;
   logic [BW-1:0]     bit_cnt;
   logic [WCW-1:0]    word_cnt, wc_new;
   logic [RCW-1:0]    rst_cnt;

   // every state starts with a fresh half-period
   assign restart = (state_d != state_q);

   hcms_tick_div #(.DIV(CLK_DIV)) u_tick (
      .clk     (clk),
      .rst     (rst),
      .restart (restart),
      .tick    (tick)
   );

   assign last_bit  = (bit_cnt == BW'(DATA_W - 1));
   assign wc_new    = (state_q == IDLE) ? WCW'(1) : word_cnt + WCW'(1);
   assign s.s_ready = ready_w;

   assign busy     = (state_q != IDLE);
   assign done     = (state_q == LATCH) && tick;
   assign err_len  = err_q;
   assign ser_data = ser_q;
   assign reg_sel  = rs_q;
   assign reset_n  = (state_q != RST_HOLD);
   assign ser_clk  = !((state_q == SHIFT) && !half_q);
   assign ce_n     = !((state_q == SETUP) || (state_q == SHIFT) || (state_q == NEXT));

   // next-state and handshake decode
   always_comb begin
      state_d = state_q;
      ready_w = 1'b0;
      accept  = 1'b0;
      case (state_q)
         RST_HOLD: if (rst_cnt == RCW'(RESET_CYCLES - 1)) state_d = IDLE;
         IDLE: begin
            if (pend_q || disp_rst) begin
               state_d = RST_HOLD;
            end else begin
               ready_w = 1'b1;
               if (s.s_valid) begin
                  accept  = 1'b1;
                  state_d = SETUP;
               end
            end
         end
         SETUP: if (tick) state_d = SHIFT;
         SHIFT: if (tick && half_q && last_bit) state_d = last_q ? LATCH : NEXT;
         NEXT: begin
            ready_w = 1'b1;
            if (s.s_valid) begin
               accept  = 1'b1;
               state_d = SHIFT;
            end
         end
         LATCH: if (tick) state_d = IDLE;
         default: state_d = RST_HOLD;
      endcase
   end

   // state register; rst aborts any frame in flight
   always_ff @(posedge clk) begin
      if (rst) state_q <= RST_HOLD;
      else     state_q <= state_d;
   end

   // display reset hold timer, cleared whenever not holding
   always_ff @(posedge clk) begin
      if (rst || state_q != RST_HOLD) rst_cnt <= '0;
      else                            rst_cnt <= rst_cnt + RCW'(1);
   end

   // serial clock phase: low half first, then high half
   always_ff @(posedge clk) begin
      if (rst || restart)              half_q <= 1'b0;
      else if (state_q == SHIFT && tick) half_q <= ~half_q;
   end

   // word load and bit shifting; DIN moves only with the falling clock
   always_ff @(posedge clk) begin
      if (rst) begin
         sh_q     <= '0;
         ser_q    <= 1'b0;
         rs_q     <= REG_DOT;
         last_q   <= 1'b0;
         trunc_q  <= 1'b0;
         word_cnt <= '0;
         bit_cnt  <= '0;
      end else if (accept) begin
         sh_q     <= s.s_data;
         ser_q    <= s.s_data[DATA_W-1];
         bit_cnt  <= '0;
         word_cnt <= wc_new;
         last_q   <= s.s_last || (wc_new == WCW'(MAX_FRAME));
         trunc_q  <= !s.s_last && (wc_new == WCW'(MAX_FRAME));
         if (state_q == IDLE) rs_q <= s.s_cmd;
      end else if (state_q == SHIFT && tick && half_q && !last_bit) begin
         sh_q    <= {sh_q[DATA_W-2:0], 1'b0};
         ser_q   <= sh_q[DATA_W-2];
         bit_cnt <= bit_cnt + BW'(1);
      end
   end

   // length-guard error flag, high on the first LATCH cycle
   always_ff @(posedge clk) begin
      if (rst) err_q <= 1'b0;
      else     err_q <= (state_q == SHIFT) && (state_d == LATCH) && trunc_q;
   end

   // sticky display-reset request, serviced from IDLE
   always_ff @(posedge clk) begin
      if (rst)                                         pend_q <= 1'b0;
      else if (state_q == IDLE && state_d == RST_HOLD) pend_q <= 1'b0;
      else if (disp_rst && state_q != IDLE)            pend_q <= 1'b1;
   end
endmodule

// File: tb/tb_hcms_stream_tx.sv
// Directed bench for hcms_stream_tx with CLK_DIV=2, MAX_FRAME=4, RESET_CYCLES=32.
module tb_hcms_stream_tx;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic disp_rst = 1'b0;
   logic busy, done, err_len, ser_data, ser_clk, reg_sel, ce_n, reset_n;

   hcms_stream_tx_if #(.DATA_W(8)) sif ();

   hcms_stream_tx #(
      .DATA_W(8), .CLK_DIV(2), .MAX_FRAME(4), .RESET_CYCLES(32)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .s        (sif),
      .disp_rst (disp_rst),
      .busy     (busy),
      .done     (done),
      .err_len  (err_len),
      .ser_data (ser_data),
      .ser_clk  (ser_clk),
      .reg_sel  (reg_sel),
      .ce_n     (ce_n),
      .reset_n  (reset_n)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // pin monitor: rising-edge bit capture, pulse counts, CE/RS stability
   int          edge_cnt = 0, done_cnt = 0, err_cnt = 0, viol_cnt = 0;
   logic [63:0] mon_bits = '0;
   logic        clk_d = 1'b1, ce_d = 1'b1, rs_d = 1'b0, rst_seen = 1'b1;

   always @(posedge clk) rst_seen = rst;

   always @(negedge clk) begin
      if (!rst_seen) begin
         if (ser_clk === 1'b1 && clk_d === 1'b0 && ce_n === 1'b0) begin
            edge_cnt++;
            mon_bits = {mon_bits[62:0], ser_data};
         end
         if ((clk_d === 1'b0 || ser_clk === 1'b0) && (ce_n !== ce_d || reg_sel !== rs_d))
            viol_cnt++;
      end
      if (done === 1'b1) done_cnt++;
      if (err_len === 1'b1) err_cnt++;
      clk_d = ser_clk;
      ce_d  = ce_n;
      rs_d  = reg_sel;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // present a word and hold it until accepted; returns on the following negedge
   task automatic push(input logic [7:0] d, input logic l, input logic c, output logic ok);
      sif.s_data = d; sif.s_last = l; sif.s_cmd = c; sif.s_valid = 1'b1; ok = 1'b0;
      for (int i = 0; i < 500 && !ok; i++) begin
         if (sif.s_ready === 1'b1) ok = 1'b1;
         @(negedge clk);
      end
      sif.s_valid = 1'b0;
   endtask

   // cycles from the current one until done is seen (inclusive)
   task automatic wait_done(output int cyc);
      cyc = 1;
      while (done !== 1'b1 && cyc < 500) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   // cycles until s_ready, counting cycles with reset_n low
   task automatic wait_ready(output int n, output int lows);
      n = 0; lows = 0;
      while (sif.s_ready !== 1'b1 && n < 500) begin
         if (reset_n === 1'b0) lows++;
         @(negedge clk);
         n++;
      end
   endtask

   initial begin
      logic ok, hi_ok, all_ok;
      int   cyc, lows, n, e0, d0, r0;
      sif.s_valid = 1'b0; sif.s_data = '0; sif.s_last = 1'b0; sif.s_cmd = 1'b0;

      // 1: reset
      @(posedge clk); @(negedge clk);
      chk("rst_ser_clk", ser_clk, 1); chk("rst_ce_n", ce_n, 1);
      chk("rst_ser_data", ser_data, 0); chk("rst_reg_sel", reg_sel, 0);
      chk("rst_reset_n", reset_n, 0); chk("rst_s_ready", sif.s_ready, 0);
      chk("rst_busy", busy, 1); chk("rst_done", done, 0); chk("rst_err", err_len, 0);
      rst = 1'b0;
      lows = 0; hi_ok = 1'b1;
      for (int k = 0; k < 32; k++) begin
         if (reset_n === 1'b0) lows++;
         if (!(ser_clk === 1'b1 && ce_n === 1'b1)) hi_ok = 1'b0;
         @(negedge clk);
      end
      chk("rst_low_cycles", lows, 32); chk("rst_pins_idle", hi_ok, 1);
      chk("rst_release", reset_n, 1); chk("idle_busy", busy, 0); chk("idle_ready", sif.s_ready, 1);

      // 2: single control word 0x4F
      #1; e0 = edge_cnt; d0 = done_cnt; r0 = err_cnt;
      push(8'h4F, 1'b1, 1'b1, ok); chk("t2_accept", ok, 1);
      chk("t2_reg_sel", reg_sel, 1); chk("t2_ce_setup", ce_n, 0);
      chk("t2_clk_setup", ser_clk, 1); chk("t2_din_msb", ser_data, 0);
      wait_done(cyc); chk("t2_latency", cyc, 36); chk("t2_ce_at_done", ce_n, 1);
      #1;
      chk("t2_edges", edge_cnt - e0, 8); chk("t2_bits", mon_bits[7:0], 8'h4F);
      chk("t2_done_cnt", done_cnt - d0, 1); chk("t2_err_cnt", err_cnt - r0, 0);
      @(negedge clk);
      chk("t2_idle_busy", busy, 0); chk("t2_idle_ready", sif.s_ready, 1); chk("t2_done_off", done, 0);

      // 3: three-word dot frame with a 10-cycle stall before word 2
      #1; e0 = edge_cnt; d0 = done_cnt;
      push(8'hAA, 1'b0, 1'b0, ok); chk("t3_accept1", ok, 1);
      wait_ready(n, lows); chk("t3_next_reached", n < 500, 1);
      hi_ok = 1'b1;
      for (int k = 0; k < 10; k++) begin
         if (!(ser_clk === 1'b1 && ce_n === 1'b0 && sif.s_ready === 1'b1)) hi_ok = 1'b0;
         @(negedge clk);
      end
      chk("t3_stall_pins", hi_ok, 1);
      push(8'h55, 1'b0, 1'b0, ok); chk("t3_accept2", ok, 1);
      push(8'hFF, 1'b1, 1'b1, ok); chk("t3_accept3", ok, 1);
      wait_done(cyc); chk("t3_last_latency", cyc, 34); chk("t3_reg_sel", reg_sel, 0);
      #1;
      chk("t3_edges", edge_cnt - e0, 24); chk("t3_bits", mon_bits[23:0], 24'hAA55FF);
      chk("t3_done_cnt", done_cnt - d0, 1);

      // 4: overflow at MAX_FRAME=4 with six words
      @(negedge clk); #1; e0 = edge_cnt; d0 = done_cnt; r0 = err_cnt; all_ok = 1'b1;
      push(8'h11, 1'b0, 1'b0, ok); all_ok &= ok;
      push(8'h22, 1'b0, 1'b0, ok); all_ok &= ok;
      push(8'h33, 1'b0, 1'b0, ok); all_ok &= ok;
      push(8'h44, 1'b0, 1'b0, ok); all_ok &= ok;
      push(8'h55, 1'b0, 1'b1, ok); all_ok &= ok;
      #1;
      chk("t4_f1_done", done_cnt - d0, 1); chk("t4_f1_err", err_cnt - r0, 1);
      chk("t4_f1_edges", edge_cnt - e0, 32); chk("t4_f1_bits", mon_bits[31:0], 32'h11223344);
      chk("t4_f2_reg_sel", reg_sel, 1);
      push(8'h66, 1'b1, 1'b0, ok); all_ok &= ok;
      chk("t4_accepts", all_ok, 1);
      wait_done(cyc); chk("t4_f2_reg_sel_end", reg_sel, 1);
      #1;
      chk("t4_done_total", done_cnt - d0, 2); chk("t4_err_total", err_cnt - r0, 1);
      chk("t4_edges", edge_cnt - e0, 48); chk("t4_bits", mon_bits[47:0], 48'h112233445566);

      // 5: rst during bit 3 of word 2, then a clean frame
      @(negedge clk);
      push(8'hC3, 1'b0, 1'b0, ok); chk("t5_accept1", ok, 1);
      push(8'h3C, 1'b1, 1'b0, ok); chk("t5_accept2", ok, 1);
      repeat (13) @(negedge clk);
      chk("t5_mid_bit_low", ser_clk, 0);
      #1; d0 = done_cnt;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t5_ce_n", ce_n, 1); chk("t5_ser_clk", ser_clk, 1);
      chk("t5_reset_n", reset_n, 0); chk("t5_done", done, 0);
      wait_ready(n, lows); chk("t5_hold", n, 32); chk("t5_hold_low", lows, 32);
      #1; chk("t5_no_done", done_cnt - d0, 0); e0 = edge_cnt;
      push(8'hA5, 1'b1, 1'b0, ok); chk("t5_accept3", ok, 1);
      wait_done(cyc); chk("t5_latency", cyc, 36);
      #1;
      chk("t5_edges", edge_cnt - e0, 8); chk("t5_bits", mon_bits[7:0], 8'hA5);
      chk("t5_done_cnt", done_cnt - d0, 1);

      // 6: disp_rst during word 1 is deferred until the frame completes
      @(negedge clk); #1; e0 = edge_cnt; d0 = done_cnt;
      push(8'h81, 1'b0, 1'b0, ok); chk("t6_accept1", ok, 1);
      disp_rst = 1'b1;
      @(negedge clk);
      disp_rst = 1'b0;
      chk("t6_still_busy", ce_n, 0);
      push(8'h7E, 1'b1, 1'b0, ok); chk("t6_accept2", ok, 1);
      wait_done(cyc); chk("t6_done_seen", done, 1);
      @(negedge clk);
      chk("t6_idle_ready", sif.s_ready, 0); chk("t6_idle_reset_n", reset_n, 1);
      @(negedge clk);
      wait_ready(n, lows); chk("t6_hold", n, 32); chk("t6_hold_low", lows, 32);
      #1;
      chk("t6_done_cnt", done_cnt - d0, 1); chk("t6_edges", edge_cnt - e0, 16);
      chk("t6_bits", mon_bits[15:0], 16'h817E);

      chk("ce_rs_stable", viol_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/hcms_stream_tx.md
Name: hcms_stream_tx

Overview:
- Parametrised serial transmitter for chained HCMS-29xx dot-matrix displays.
- Accepts a ready/valid byte stream framed by a last flag and shifts it MSB-first. Generates a divided serial clock and handles CE framing, register select and a timed display reset.
- Sits between the display controller (font/dot-data fetch, control-word builder) and the display pins.
- Replaces per-byte load/ready pulsing with continuous multi-byte frames of up to MAX_FRAME words.

Parameters:
- DATA_W, 8: bits per stream word.
- CLK_DIV, 4: clk cycles per ser_clk half-period; legal range 2..255.
- MAX_FRAME, 160: maximum words per frame (4 chips x 40 columns).
- RESET_CYCLES, 32: clk cycles reset_n is held low per display reset.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- s_data  in  DATA_W  word to transmit, MSB first.
- s_valid  in  1  s_data valid.
- s_last  in  1  marks final word of frame.
- s_cmd  in  1  1 = control register frame, 0 = dot register frame; sampled with first word only.
- s_ready  out  1  word accepted when s_valid && s_ready.
- disp_rst  in  1  one-cycle request for a display hardware reset.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when a frame is latched.
- err_len  out  1  one-cycle pulse when a frame is truncated at MAX_FRAME.
- ser_data  out  1  display DIN.
- ser_clk  out  1  display CLK; idles high.
- reg_sel  out  1  display RS.
- ce_n  out  1  display CE, active-low.
- reset_n  out  1  display RESET, active-low.

Behaviour:
- Reset values (rst high, and the cycle after):
  - ser_clk=1, ce_n=1, ser_data=0, reg_sel=0, reset_n=0.
  - s_ready=0, busy=1, done=0, err_len=0.
  - State = RST_HOLD; pending disp_rst cleared.
- rst mid-frame aborts immediately; no done pulse; the partial frame is discarded.
- Tick generator: counter 0..CLK_DIV-1 that restarts on every state entry; tick = counter==CLK_DIV-1.
- RST_HOLD:
  - reset_n=0 for exactly RESET_CYCLES clk cycles, then reset_n=1 and go to IDLE.
- IDLE:
  - s_ready=1, busy=0, ce_n=1, ser_clk=1.
  - A pending or current disp_rst takes priority over s_valid: go to RST_HOLD with s_ready=0 that cycle.
  - On an s_valid handshake: load the shift register, latch reg_sel=s_cmd, set word_cnt=1, capture s_last, go to SETUP.
- SETUP:
  - ce_n=0, ser_data=shift MSB, ser_clk=1; hold one half-period (CLK_DIV cycles).
  - Gives setup time of RS and CE to the first clock edge. Then SHIFT.
- SHIFT:
  - Alternating half-periods, DATA_W bits per word, 2*DATA_W*CLK_DIV cycles per word.
  - First half: ser_clk=0, ser_data=current bit.
  - Second half: ser_clk=1; the display samples on the rising edge.
  - ser_data changes only while ser_clk transitions low.
  - After the last bit's high half: if the captured last flag is set, go to LATCH; else go to NEXT.
- NEXT:
  - ser_clk=1, ce_n=0, s_ready=1.
  - Stall indefinitely if s_valid=0; a stall is legal because the display latches on the CE rising edge.
  - On handshake: load the word, increment word_cnt, capture s_last, then SHIFT directly with no SETUP.
  - s_cmd is ignored here; reg_sel is constant for the whole frame.
- Length guard:
  - If word_cnt==MAX_FRAME and the captured last flag is 0, treat the word as last.
  - Go to LATCH and pulse err_len in the LATCH entry cycle.
  - Subsequent words belong to a new frame.
- LATCH:
  - ce_n=1 (rising edge latches data) with ser_clk=1; hold CLK_DIV cycles.
  - Pulse done on the final cycle, then go to IDLE.
- disp_rst outside IDLE sets a sticky pending bit, serviced on the next IDLE entry.
- reg_sel and ce_n never change while ser_clk=0.

Decomposition:
- hcms_pkg holds:
  - the state enum (RST_HOLD, IDLE, SETUP, SHIFT, NEXT, LATCH);
  - REG_DOT=0 and REG_CTRL=1;
  - control-word constants (CW0 brightness/PWM field, CW1 serial/simultaneous mode bit).
- One sub-module, hcms_tick_div: parametrised half-period counter with a restart input and a tick output; reused by the future PWM brightness block.

Test Plan:
1. Reset: rst high 1 cycle, RESET_CYCLES=32 -> reset_n low exactly 32 cycles after rst deasserts, then busy=0, s_ready=1; ser_clk=1 and ce_n=1 throughout.
2. Single control word: CLK_DIV=2, s_data=0x4F, s_cmd=1, s_last=1 -> reg_sel=1 and ce_n=0 before the first edge; 8 rising edges sample 0,1,0,0,1,1,1,1; ce_n rises then done pulses; total 2+32+2 cycles after handshake.
3. Multi-word dot frame with stall: 3 words 0xAA,0x55,0xFF, s_valid low 10 cycles before word 2 -> 24 rising edges with the correct bits; ser_clk held high and ce_n low during the stall; a single done; reg_sel=0.
4. Overflow: MAX_FRAME=4, 6 words with s_last on word 6 -> first frame ends after word 4 with err_len and done pulses; words 5-6 form a second frame with done and no err_len.
5. rst mid-SHIFT at bit 3 of word 2 -> next cycle: ce_n=1, ser_clk=1, reset_n=0, no done; a new frame after RST_HOLD transmits correctly.
6. disp_rst asserted during word 1 of a 2-word frame -> the frame completes with done; RST_HOLD is then entered (reset_n low 32 cycles) before s_ready rises.
